hdmi_line_buffer_ring: RTL

- Parametrised ring of NUM_LINES single-port line BRAMs for streaming HDMI pixels into conv layer 0.
- Write-line rotation, column addressing and fill tracking are internal, so the upstream capture logic no longer drives per-bank addresses or write enables.
- Each accepted pixel produces one vertical column of NUM_LINES taps: NUM_LINES-1 stored lines plus the live pixel.
- Sits between the HDMI pixel capture and the conv0 window/MAC stage.

---
 rtl/hdmi_line_buffer_ring.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hdmi_line_buffer_ring.sv
// Line buffer ring: NUM_LINES single-port line BRAMs that turn an HDMI
// pixel stream into one vertical tap column per pixel for conv layer 0.
//   clk, reset    : clock, synchronous active-high reset
//   in_valid      : pixel strobe (no backpressure)
//   in_sof        : first pixel of a frame, qualified by in_valid
//   in_data       : pixel
//   out_valid     : tap column valid, 2 cycles after the input edge
//   out_taps      : tap k at [k*DATA_W +: DATA_W], k=0 oldest line,
//                   k=NUM_LINES-1 the live pixel
//   out_col       : column of the output tap column
//   out_eol       : last column of a line
//   out_sof       : first output column of a frame
module hdmi_line_buffer_ring #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 11,
  parameter int LINE_LEN  = 1920,
  parameter int NUM_LINES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  output logic [NUM_LINES*DATA_W-1:0] out_taps,
  output logic [ADDR_W-1:0]           out_col,
  output logic                        out_eol,
  output logic                        out_sof
);

  localparam int LW = (NUM_LINES > 2) ? $clog2(NUM_LINES) : 1;
  localparam int TW = NUM_LINES * DATA_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES - 1);

  typedef struct packed {
    logic              valid;
    logic              sof;
    logic              eol;
    logic [ADDR_W-1:0] col;
  } meta_t;

  // Bank holding the k-th oldest stored line, relative to the bank
  // currently being written.
  function automatic logic [LW-1:0] bank_sel(
    input logic [LW-1:0] wl,
    input int            k
  );
    int i;
    i = int'(wl) + 1 + k;
    if (i >= NUM_LINES) i = i - NUM_LINES;
    return LW'(i);
  endfunction

  logic [ADDR_W-1:0] col;
  logic [LW-1:0]     wr_line;
  logic [LW-1:0]     lines_filled;
  logic              sof_pend;

  logic [ADDR_W-1:0] eff_col;
  logic [LW-1:0]     lf_base;
  logic              pend_base;
  logic              at_eol;
  logic              filled;
  logic              first_col;
  meta_t             meta_d;

  // in_sof restarts the frame on this very pixel: it lands in column 0
  // of the current bank and counts as frame line 0.
  always_comb begin
    eff_col   = in_sof ? '0 : col;
    lf_base   = in_sof ? '0 : lines_filled;
    pend_base = in_sof | sof_pend;
    at_eol    = (eff_col == LAST_COL);
    filled    = (lf_base == LAST_LINE);
    first_col = filled & pend_base & (eff_col == '0);
    meta_d.valid = in_valid & filled;
    meta_d.sof   = in_valid & first_col;
    meta_d.eol   = in_valid & filled & at_eol;
    meta_d.col   = eff_col;
  end

  // Saturated lines_filled stays at NUM_LINES-1 on every later line, so
  // sof_pend marks that the frame has not produced its first column yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      col          <= '0;
      wr_line      <= '0;
      lines_filled <= '0;
      sof_pend     <= 1'b1;
    end else if (in_valid) begin
      sof_pend <= pend_base & ~first_col;
      if (at_eol) begin
        col     <= '0;
        wr_line <= (wr_line == LAST_LINE) ? '0 : wr_line + 1'b1;
        lines_filled <= filled ? lf_base : lf_base + 1'b1;
      end else begin
        col          <= eff_col + 1'b1;
        lines_filled <= lf_base;
      end
    end
  end

  // One bank is written, all others read at the same column. The write
  // bank is never read, so read-during-write behaviour never matters.
  logic [DATA_W-1:0] rd_bus [NUM_LINES];

  for (genvar b = 0; b < NUM_LINES; b++) begin : g_bank
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q;
    logic              we;

    assign we = in_valid & (wr_line == LW'(b));

    always_ff @(posedge clk) begin
      if (in_valid) begin
        if (we) mem[eff_col] <= in_data;
        else    rd_q <= mem[eff_col];
      end
    end

    assign rd_bus[b] = rd_q;
  end

  meta_t             s0_meta;
  logic [DATA_W-1:0] s0_pix;
  logic [LW-1:0]     s0_wl;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_meta <= '0;
      s0_pix  <= '0;
      s0_wl   <= '0;
    end else begin
      s0_meta <= meta_d;
      s0_pix  <= in_data;
      s0_wl   <= wr_line;
    end
  end

  logic [TW-1:0] taps_d;

  for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_tap
    logic [LW-1:0] sel;
    assign sel = bank_sel(s0_wl, k);
    assign taps_d[k*DATA_W +: DATA_W] = rd_bus[sel];
  end

  assign taps_d[TW-1 -: DATA_W] = s0_pix;

  meta_t         s1_meta;
  logic [TW-1:0] s1_taps;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_meta <= '0;
      s1_taps <= '0;
    end else begin
      s1_meta <= s0_meta;
      s1_taps <= taps_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_col   <= '0;
      out_taps  <= '0;
    end else begin
      out_valid <= s1_meta.valid;
      out_sof   <= s1_meta.sof;
      out_eol   <= s1_meta.eol;
      out_col   <= s1_meta.col;
      out_taps  <= s1_taps;
    end
  end

endmodule
